// File: rtl/hc4_prog_loader_pkg.sv
// Shared definitions for the HC4 program loader: state encodings, defaults
// and the in-frame predicate used by the loader and its idle timer.
package hc4_prog_loader_pkg;

  localparam int         PROG_ADDR_W   = 12;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_RUN    = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  // True while a frame is being received (LEN_HI through CSUM).
  function automatic logic in_frame(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/hc4_loader_timer.sv
// Idle counter for the loader: counts enabled cycles up to LIMIT and holds
// there with expired high until cleared.
module hc4_loader_timer #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic nReset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  assign expired = (cnt == W'(LIMIT));

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hc4_prog_loader.sv
// Byte-stream boot loader for the HC4 program memory. Receives a framed image
// (sync, length, data, checksum), writes it to memory and releases the core.
module hc4_prog_loader
  import hc4_prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = PROG_ADDR_W,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int         TIMEOUT   = 0,
  parameter int         BOOT_RUN  = 0
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_nreset,
  output logic              busy,
  output logic              error,
  output state_t            state_dbg
);

  // Handshake: a byte transfers on posedge clk when in_valid & in_ready; the
  // loader is always ready because every memory write completes in one cycle.
  assign in_ready = 1'b1;

  state_t            state;
  logic [ADDR_W-9:0] len_hi;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        sum;
  logic [7:0]        csum_total;
  logic              accept;
  logic              tmr_expired;

  assign accept     = in_valid & in_ready;
  assign csum_total = sum + in_data;
  assign state_dbg  = state;

  generate
    if (TIMEOUT > 0) begin : g_timer
      logic tmr_clear;
      logic tmr_enable;
      assign tmr_enable = in_frame(state);
      assign tmr_clear  = !in_frame(state) || accept;
      hc4_loader_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk     (clk),
        .nReset  (nReset),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (tmr_expired)
      );
    end else begin : g_no_timer
      assign tmr_expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state       <= (BOOT_RUN != 0) ? ST_RUN : ST_IDLE;
      core_nreset <= (BOOT_RUN != 0);
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      error       <= 1'b0;
      len_hi      <= '0;
      count       <= '0;
      addr        <= '0;
      sum         <= '0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (in_data == SYNC_BYTE) begin
              state <= ST_LEN_HI;
              busy  <= 1'b1;
            end
          end
          ST_LEN_HI: begin
            len_hi <= in_data[ADDR_W-9:0];
            state  <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            // A zero length wraps the countdown and so spans the whole memory.
            count <= {len_hi, in_data};
            addr  <= '0;
            sum   <= '0;
            state <= ST_DATA;
          end
          ST_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= in_data;
            sum       <= csum_total;
            addr      <= addr + 1'b1;
            count     <= count - 1'b1;
            if (count == ADDR_W'(1)) begin
              state <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            busy <= 1'b0;
            if (csum_total == 8'h00) begin
              state       <= ST_RUN;
              core_nreset <= 1'b1;
              error       <= 1'b0;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
          ST_RUN: begin
            if (in_data == SYNC_BYTE) begin
              state       <= ST_LEN_HI;
              core_nreset <= 1'b0;
              busy        <= 1'b1;
            end
          end
          ST_ERR: begin
            if (in_data == SYNC_BYTE) begin
              state <= ST_LEN_HI;
              error <= 1'b0;
              busy  <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (in_frame(state) && tmr_expired) begin
        state <= ST_ERR;
        error <= 1'b1;
        busy  <= 1'b0;
      end
    end
  end

endmodule
